// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Purpose:
//   Two-port arbiter and access sequencer in front of a single-port data RAM
//   (DATA_W x 2**ADDR_W words, synchronous write, read capture on a rising
//   rden edge). Port 0 is the control/fetch requester, port 1 the DMA/host
//   requester. Accesses are serialised, the RAM strobes are generated here and
//   read data is returned to the port that issued the read.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata     request from port N (N = 0, 1)
//   reqN_ready                   request accepted this cycle (combinational)
//   reqN_rvalid                  one-cycle pulse, reqN_rdata is valid
//   reqN_rdata                   read data, held until the next read on port N
//   ram_data/address/wren/rden   registered RAM controls
//   ram_q                        RAM read data
//   dbg_state_o                  current sequencer state (IDLE/WR/RD_STB/RD_CAP)
//
// Configuration:
//   RAM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins a contest and the
//                          round-robin pointer is removed (port 1 may starve).
//                          When undefined, contests alternate between ports.
//
// Handshake:
//   A requester raises reqN_valid together with we/addr/wdata and holds all of
//   them stable until it sees reqN_ready high; the request is transferred on
//   the rising clk edge where valid and ready are both high. reqN_ready is only
//   ever high in IDLE and only for the granted port, so at most one transfer
//   happens per edge. Dropping valid before ready is a protocol violation.
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,

  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RD_STB = 2'd2,
    ST_RD_CAP = 2'd3
  } state_e;

  state_e            state_q;
  logic              owner_q;       // port whose access is in flight
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic              last_gnt_q;    // port granted most recently
`endif
  logic [DATA_W-1:0] ram_data_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic              ram_wren_q;
  logic              ram_rden_q;
  logic              req0_rvalid_q;
  logic              req1_rvalid_q;
  logic [DATA_W-1:0] req0_rdata_q;
  logic [DATA_W-1:0] req1_rdata_q;

  // Grant decision and the muxed request of the granted port.
  logic              gnt_any_d;
  logic              gnt_port_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  always_comb begin
    gnt_any_d  = 1'b0;
    gnt_port_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any_d  = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        gnt_port_d = 1'b0;
`else
        // The port that did not win last time takes this contest.
        gnt_port_d = ~last_gnt_q;
`endif
      end else if (req0_valid) begin
        gnt_any_d  = 1'b1;
        gnt_port_d = 1'b0;
      end else if (req1_valid) begin
        gnt_any_d  = 1'b1;
        gnt_port_d = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we_d    = req0_we;
    sel_addr_d  = req0_addr;
    sel_wdata_d = req0_wdata;
    if (gnt_port_d) begin
      sel_we_d    = req1_we;
      sel_addr_d  = req1_addr;
      sel_wdata_d = req1_wdata;
    end
  end

  assign req0_ready = gnt_any_d & ~gnt_port_d;
  assign req1_ready = gnt_any_d &  gnt_port_d;

  // Sequencer. Writes take WR for one cycle (RAM writes on the edge leaving
  // WR). Reads raise rden for exactly one cycle in RD_STB so that every read
  // gets a fresh rising edge, then capture ram_q on the edge leaving RD_CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_gnt_q    <= 1'b1;        // port 0 wins the first contest
`endif
      ram_data_q    <= '0;
      ram_address_q <= '0;
      ram_wren_q    <= 1'b0;
      ram_rden_q    <= 1'b0;
      req0_rvalid_q <= 1'b0;
      req1_rvalid_q <= 1'b0;
      req0_rdata_q  <= '0;
      req1_rdata_q  <= '0;
    end else begin
      // rvalid is a single-cycle pulse; only RD_CAP raises it.
      req0_rvalid_q <= 1'b0;
      req1_rvalid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (gnt_any_d) begin
            owner_q       <= gnt_port_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_gnt_q    <= gnt_port_d;
`endif
            ram_address_q <= sel_addr_d;
            ram_data_q    <= sel_wdata_d;
            if (sel_we_d) begin
              ram_wren_q <= 1'b1;
              state_q    <= ST_WR;
            end else begin
              ram_rden_q <= 1'b1;
              state_q    <= ST_RD_STB;
            end
          end
        end

        ST_WR: begin
          ram_wren_q <= 1'b0;
          state_q    <= ST_IDLE;
        end

        ST_RD_STB: begin
          ram_rden_q <= 1'b0;
          state_q    <= ST_RD_CAP;
        end

        ST_RD_CAP: begin
          if (owner_q) begin
            req1_rdata_q  <= ram_q;
            req1_rvalid_q <= 1'b1;
          end else begin
            req0_rdata_q  <= ram_q;
            req0_rvalid_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end

        default: begin
          ram_wren_q <= 1'b0;
          ram_rden_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_data    = ram_data_q;
  assign ram_address = ram_address_q;
  assign ram_wren    = ram_wren_q;
  assign ram_rden    = ram_rden_q;
  assign req0_rvalid = req0_rvalid_q;
  assign req1_rvalid = req1_rvalid_q;
  assign req0_rdata  = req0_rdata_q;
  assign req1_rdata  = req1_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter with a behavioural single-port RAM attached.
// Read data returned on reqN_rdata is checked against per-port expected
// queues; handshake and strobe timing is checked at fixed points after the
// accept edge. All inputs change 1 time unit after a rising clk edge.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int DW = 14;
  localparam int AW = 12;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WR     = 2'd1;
  localparam logic [1:0] S_RD_STB = 2'd2;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT signals
  logic          req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_address;
  logic          ram_wren, ram_rden;
  logic [DW-1:0] ram_q;
  logic [1:0]    dbg_state;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_ready  (req0_ready),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req1_valid  (req1_valid),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_ready  (req1_ready),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata),
    .ram_data    (ram_data),
    .ram_address (ram_address),
    .ram_wren    (ram_wren),
    .ram_rden    (ram_rden),
    .ram_q       (ram_q),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- RAM model
  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd13 + 32'd7) ^ 32'h2A5;
    return t[DW-1:0];
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
    ram_q = '0;
  end

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] = ram_data;
    if (ram_rden) ram_q <= mem[ram_address];
  end

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic exp_last;            // port granted most recently (reference model)
  int   overlap_cnt = 0;     // cycles with wren and rden both high
  int   rden_long_cnt = 0;   // cycles where rden stayed high a second cycle
  logic rden_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_winner(input logic v0, input logic v1);
`ifdef RAM_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    return (v0 && v1) ? !exp_last : v1;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_rvalid) begin
        if (exp_q0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
        else chk("rdata0", 32'(req0_rdata), 32'(exp_q0.pop_front()));
      end
      if (req1_rvalid) begin
        if (exp_q1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
        else chk("rdata1", 32'(req1_rdata), 32'(exp_q1.pop_front()));
      end
      if (ram_wren && ram_rden) overlap_cnt++;
      if (ram_rden && rden_prev) rden_long_cnt++;
      rden_prev = ram_rden;
    end else begin
      rden_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on port p and wait (bounded) for it to be accepted.
  // Entered and left 1 unit after a rising edge.
  task automatic do_req(input logic p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    logic done;
    done = 1'b0;
    if (p) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (p ? req1_ready : req0_ready) begin
        done = 1'b1;
        if (!we) begin
          if (p) exp_q1.push_back(exp_rd);
          else   exp_q0.push_back(exp_rd);
        end
        exp_last = p;
      end
      tick();
    end
    if (p) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
    chk("req_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (exp_q0.size() + exp_q1.size()) != 0; i++) tick();
    chk("drain_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : stim
    int   n0, n1;
    logic w, got;

    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    exp_last   = 1'b1;

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_wren",    32'(ram_wren),    32'd0);
    chk("rst_rden",    32'(ram_rden),    32'd0);
    chk("rst_address", 32'(ram_address), 32'd0);
    chk("rst_data",    32'(ram_data),    32'd0);
    chk("rst_rvalid0", 32'(req0_rvalid), 32'd0);
    chk("rst_rvalid1", 32'(req1_rvalid), 32'd0);
    chk("rst_rdata0",  32'(req0_rdata),  32'd0);
    chk("rst_rdata1",  32'(req1_rdata),  32'd0);
    chk("rst_state",   32'(dbg_state),   32'(S_IDLE));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Test 1: port 0 write 0x005 = 0x1ABC
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h005; req0_wdata = 14'h1ABC;
    #1;
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    chk("t1_ready1", 32'(req1_ready), 32'd0);
    tick();
    exp_last = 1'b0;
    chk("t1_wren",     32'(ram_wren),    32'd1);
    chk("t1_address",  32'(ram_address), 32'h005);
    chk("t1_data",     32'(ram_data),    32'h1ABC);
    chk("t1_state",    32'(dbg_state),   32'(S_WR));
    chk("t1_ready0_1c", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    tick();
    chk("t1_wren_low", 32'(ram_wren),  32'd0);
    chk("t1_idle",     32'(dbg_state), 32'(S_IDLE));

    // Test 2: port 0 read 0x005
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h005;
    #1;
    chk("t2_ready0", 32'(req0_ready), 32'd1);
    exp_q0.push_back(14'h1ABC);
    tick();
    exp_last = 1'b0;
    req0_valid = 1'b0;
    chk("t2_rden_hi",  32'(ram_rden),    32'd1);
    chk("t2_wren_lo",  32'(ram_wren),    32'd0);
    tick();
    chk("t2_rden_lo",  32'(ram_rden),    32'd0);
    chk("t2_rv0_early", 32'(req0_rvalid), 32'd0);
    tick();
    chk("t2_rvalid0",  32'(req0_rvalid), 32'd1);
    chk("t2_rdata0",   32'(req0_rdata),  32'h1ABC);
    chk("t2_rvalid1",  32'(req1_rvalid), 32'd0);
    tick();
    chk("t2_rv0_pulse", 32'(req0_rvalid), 32'd0);
    chk("t2_rdata_hold", 32'(req0_rdata), 32'h1ABC);

    // Test 3: both ports hold four reads each
    n0 = 0; n1 = 0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h800;
    for (int cyc = 0; cyc < 200 && (n0 < 4 || n1 < 4); cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        w   = exp_winner(req0_valid, req1_valid);
        got = req1_ready;
        chk("t3_ready0", 32'(req0_ready), 32'(!w));
        chk("t3_ready1", 32'(req1_ready), 32'(w));
        exp_last = w;
        if (got) exp_q1.push_back(pat(req1_addr));
        else     exp_q0.push_back(pat(req0_addr));
        tick();
        if (got) begin
          n1++;
          if (n1 < 4) req1_addr = req1_addr + 12'd1;
          else        req1_valid = 1'b0;
        end else begin
          n0++;
          if (n0 < 4) req0_addr = req0_addr + 12'd1;
          else        req0_valid = 1'b0;
        end
      end else begin
        tick();
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_grants", 32'(n0 + n1), 32'd8);
    drain();
    chk("t3_no_overlap", 32'(overlap_cnt),   32'd0);
    chk("t3_rden_pulse", 32'(rden_long_cnt), 32'd0);

    // Test 4: top address write by port 1, read back by port 0
    do_req(1'b1, 1'b1, 12'hFFF, 14'h3FFF, 14'h0000);
    do_req(1'b0, 1'b0, 12'hFFF, 14'h0000, 14'h3FFF);
    drain();
    chk("t4_rdata0", 32'(req0_rdata), 32'h3FFF);

    // Test 5: reset while a read strobe is high
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h010;
    #1;
    chk("t5_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("t5_rden_hi", 32'(ram_rden),  32'd1);
    chk("t5_state",   32'(dbg_state), 32'(S_RD_STB));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rden_async", 32'(ram_rden),    32'd0);
    chk("t5_state_rst",  32'(dbg_state),   32'(S_IDLE));
    chk("t5_addr_rst",   32'(ram_address), 32'd0);
    tick();
    chk("t5_no_rvalid",  32'(req0_rvalid), 32'd0);
    #3 rst_n = 1'b1;
    exp_last = 1'b1;
    tick();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h100; req0_wdata = 14'h0123;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 12'h101; req1_wdata = 14'h0456;
    #1;
    chk("t5_first_ready0", 32'(req0_ready), 32'd1);
    chk("t5_first_ready1", 32'(req1_ready), 32'd0);
    tick();
    exp_last = 1'b0;
    req0_valid = 1'b0;
    chk("t5_wr0_addr", 32'(ram_address), 32'h100);
    tick();
    chk("t5_second_ready1", 32'(req1_ready), 32'd1);
    tick();
    exp_last = 1'b1;
    req1_valid = 1'b0;
    chk("t5_wr1_addr", 32'(ram_address), 32'h101);
    chk("t5_wr1_data", 32'(ram_data),    32'h0456);
    do_req(1'b0, 1'b0, 12'h100, 14'h0000, 14'h0123);
    do_req(1'b1, 1'b0, 12'h101, 14'h0000, 14'h0456);
    drain();

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Test 6: fixed priority, both ports requesting continuously
    n0 = 0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h200;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h900;
    for (int cyc = 0; cyc < 100 && n0 < 4; cyc++) begin
      #1;
      chk("t6_ready1_never", 32'(req1_ready), 32'd0);
      if (req0_ready) begin
        exp_q0.push_back(pat(req0_addr));
        tick();
        n0++;
        req0_addr = req0_addr + 12'd1;
      end else begin
        tick();
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t6_grants0", 32'(n0), 32'd4);
    drain();
`endif

    chk("end_overlap", 32'(overlap_cnt),   32'd0);
    chk("end_rden",    32'(rden_long_cnt), 32'd0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
